// File: rtl/fir_sample_ring.sv
// Multi-channel circular sample buffer that streams the newest N samples of one channel, newest first.
// Define FIR_RING_ZEROPAD_EN to zero taps older than the channel fill level.
module fir_sample_ring #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int NUM_CH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_start,
    input  logic [CW-1:0]     rd_ch,
    input  logic [AW:0]       rd_ntaps,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [AW-1:0]     out_tap,
    output logic              out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_mem [NUM_CH*DEPTH];
    logic [AW-1:0]     r_wptr [NUM_CH];
`ifdef FIR_RING_ZEROPAD_EN
    logic [AW:0]       r_fill [NUM_CH];
    logic [AW:0]       r_bfill;
    logic              r_rd_zero;
`endif

    logic [CW-1:0]     r_ch;
    logic [AW:0]       r_n;
    logic [AW:0]       r_k;
    logic [AW-1:0]     r_rptr;

    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic [AW-1:0]     r_rd_tap;
    logic              r_rd_last;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [AW-1:0]     r_out_tap;
    logic              r_out_last;

    logic              w_busy;
    logic              w_in_ready;
    logic              w_wr;
    logic              w_req_ok;
    logic              w_accept;
    logic              w_issue;
    logic              w_issue_last;

    assign w_busy       = (r_state != S_IDLE);
    assign w_in_ready   = !(w_busy && (in_ch == r_ch));
    assign w_wr         = in_valid && w_in_ready && (int'(in_ch) < NUM_CH);
    assign w_req_ok     = rd_start && (int'(rd_ch) < NUM_CH) && (rd_ntaps != '0);
    assign w_issue_last = (r_k == (r_n - (AW+1)'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_ok) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Hold busy through the cycle that presents the final tap
                if (r_out_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_rptr  <= '0;
`ifdef FIR_RING_ZEROPAD_EN
            r_bfill <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ch    <= rd_ch;
                r_n     <= (rd_ntaps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : rd_ntaps;
                r_k     <= '0;
                r_rptr  <= r_wptr[rd_ch] - AW'(1);
`ifdef FIR_RING_ZEROPAD_EN
                r_bfill <= r_fill[rd_ch];
`endif
            end else if (w_issue) begin
                r_k    <= r_k + (AW+1)'(1);
                r_rptr <= r_rptr - AW'(1);
            end
        end
    end

    // Sample storage: one write port, one registered read port, no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[{in_ch, r_wptr[in_ch]}] <= in_data;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[{r_ch, r_rptr}];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
`ifdef FIR_RING_ZEROPAD_EN
                r_fill[i] <= '0;
`endif
            end
        end else if (w_wr) begin
            r_wptr[in_ch] <= r_wptr[in_ch] + AW'(1);
`ifdef FIR_RING_ZEROPAD_EN
            if (r_fill[in_ch] != (AW+1)'(DEPTH)) begin
                r_fill[in_ch] <= r_fill[in_ch] + (AW+1)'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid  <= 1'b0;
            r_rd_tap    <= '0;
            r_rd_last   <= 1'b0;
`ifdef FIR_RING_ZEROPAD_EN
            r_rd_zero   <= 1'b0;
`endif
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tap   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_rd_valid  <= w_issue;
            r_rd_tap    <= r_k[AW-1:0];
            r_rd_last   <= w_issue && w_issue_last;
`ifdef FIR_RING_ZEROPAD_EN
            r_rd_zero   <= (r_k >= r_bfill);
            r_out_data  <= (r_rd_valid && !r_rd_zero) ? r_rd_data : '0;
`else
            r_out_data  <= r_rd_valid ? r_rd_data : '0;
`endif
            r_out_valid <= r_rd_valid;
            r_out_tap   <= r_rd_valid ? r_rd_tap : '0;
            r_out_last  <= r_rd_valid && r_rd_last;
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tap   = r_out_tap;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_fir_sample_ring.sv
// Randomized bench for fir_sample_ring against an array-based model of the sample ring.
// Follows FIR_RING_ZEROPAD_EN the same way the design does.
module tb_fir_sample_ring;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int NCH   = 3;
    localparam int AW    = 6;
    localparam int CW    = 2;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ch;
    logic [DW-1:0] in_data;
    logic          rd_start;
    logic [CW-1:0] rd_ch;
    logic [AW:0]   rd_ntaps;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_tap;
    logic          out_last;

    fir_sample_ring #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .NUM_CH (NCH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .rd_start  (rd_start),
        .rd_ch     (rd_ch),
        .rd_ntaps  (rd_ntaps),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tap   (out_tap),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each channel is a DEPTH-slot ring; the newest sample sits just below the write slot
    logic [DW-1:0] m_mem [NCH][DEPTH];
    int            m_wptr [NCH];
    int            m_fill [NCH];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_wptr[c] = 0;
            m_fill[c] = 0;
        end
    endtask

    task automatic model_write(input int ch, input logic [DW-1:0] d);
        m_mem[ch][m_wptr[ch]] = d;
        m_wptr[ch] = (m_wptr[ch] + 1) % DEPTH;
        if (m_fill[ch] < DEPTH) m_fill[ch] = m_fill[ch] + 1;
    endtask

    function automatic logic [DW-1:0] exp_tap(input int ch, input int base, input int fill, input int k);
`ifdef FIR_RING_ZEROPAD_EN
        if (k >= fill) return '0;
`endif
        return m_mem[ch][(base - 1 - k + 2*DEPTH) % DEPTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ch    = CW'(ch);
        in_data  = d;
        @(negedge clk);
        check("wr_ready", {31'd0, in_ready}, 32'd1);
        model_write(ch, d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic burst(input int ch, input int nt, input bit wr_during, input bit poke);
        int            n;
        int            base;
        int            fill;
        int            k;
        int            wc;
        bit            w;
        bit            busy_exp;
        bit            rdy_exp;
        bit            vexp;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_q [$];
        n    = (nt > DEPTH) ? DEPTH : nt;
        base = m_wptr[ch];
        fill = m_fill[ch];
        for (int i = 0; i < n; i++) exp_q.push_back(exp_tap(ch, base, fill, i));
        rd_start = 1'b1;
        rd_ch    = CW'(ch);
        rd_ntaps = (AW+1)'(nt);
        tick();
        rd_start = 1'b0;
        for (int c = 0; c <= n + 2; c++) begin
            w  = 1'b0;
            wc = 0;
            wd = '0;
            if (wr_during && (c < 2 || $urandom_range(0, 1) == 1)) begin
                wc       = (c < 2) ? ((ch + c) % NCH) : int'($urandom_range(0, NCH - 1));
                wd       = $urandom;
                in_valid = 1'b1;
                in_ch    = CW'(wc);
                in_data  = wd;
                w        = 1'b1;
            end
            if (poke && (c == 1 || c == n + 1)) begin
                rd_start = 1'b1;
                rd_ch    = CW'((ch + 1) % NCH);
                rd_ntaps = (AW+1)'(1);
            end
            @(negedge clk);
            busy_exp = (c <= n + 1);
            check("busy", {31'd0, busy}, {31'd0, busy_exp});
            if (w) begin
                rdy_exp = !(busy_exp && wc == ch);
                check("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
                if (rdy_exp) model_write(wc, wd);
            end
            k    = c - 2;
            vexp = (k >= 0 && k < n);
            check("out_valid", {31'd0, out_valid}, {31'd0, vexp});
            if (vexp) begin
                check("out_tap", 32'(out_tap), 32'(k));
                check("out_data", out_data, exp_q[k]);
                check("out_last", {31'd0, out_last}, {31'd0, (k == n - 1)});
            end else begin
                check("out_last_idle", {31'd0, out_last}, 32'd0);
            end
            tick();
            in_valid = 1'b0;
            rd_start = 1'b0;
        end
        @(negedge clk);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("valid_after", {31'd0, out_valid}, 32'd0);
        tick();
    endtask

    task automatic bad_req(input int ch, input int nt);
        rd_start = 1'b1;
        rd_ch    = CW'(ch);
        rd_ntaps = (AW+1)'(nt);
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bad_busy", {31'd0, busy}, 32'd0);
            check("bad_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] x;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_ch    = '0;
        in_data  = '0;
        rd_start = 1'b0;
        rd_ch    = '0;
        rd_ntaps = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tap", 32'(out_tap), 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        reset = 1'b1;
        tick();

        // Every slot gets a known value so stale-content taps are predictable
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < DEPTH; i++) wr(c, $urandom);
        do_reset();

        for (int i = 1; i <= 5; i++) wr(0, 32'(i));
        burst(0, 3, 1'b0, 1'b0);

        for (int i = 0; i < 70; i++) wr(1, 32'(i));
        burst(1, 64, 1'b0, 1'b0);

        do_reset();
        wr(0, 32'hAAAA_0001);
        wr(0, 32'hBBBB_0002);
        burst(0, 4, 1'b0, 1'b0);

        burst(0, 8, 1'b1, 1'b0);
        burst(1, 5, 1'b1, 1'b0);

        bad_req(0, 0);
        bad_req(NCH, 4);
        burst(2, 6, 1'b0, 1'b1);
        burst(1, DEPTH + 1, 1'b0, 1'b0);
        burst(0, 1, 1'b1, 1'b1);

        rd_start = 1'b1;
        rd_ch    = '0;
        rd_ntaps = (AW+1)'(8);
        in_ch    = '0;
        tick();
        rd_start = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("mid_valid", {31'd0, out_valid}, 32'd1);
        check("mid_tap", 32'(out_tap), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        check("arst_data", out_data, 32'd0);
        check("arst_tap", 32'(out_tap), 32'd0);
        check("arst_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tick();
        x = $urandom;
        wr(0, x);
        burst(0, 3, 1'b0, 1'b0);

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 8)) wr(int'($urandom_range(0, NCH - 1)), $urandom);
            burst(int'($urandom_range(0, NCH - 1)), int'($urandom_range(1, 70)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sample_ring.md
# fir_sample_ring

Multi-channel circular sample buffer feeding the FIR tap engine. It stores incoming samples per channel with an internal auto-wrapping write pointer. On request, it streams the most recent N samples of one channel, newest first, one per cycle. It replaces external write/read address management and adds fill tracking, zero-padding at start-up and write/read collision protection.

## Interface
- DATA_W, 32, sample width in bits
- DEPTH, 64, samples stored per channel; power of two, 2..256
- NUM_CH, 2, number of independent channels, 1..16
- AW, log2(DEPTH), local: pointer width; CW = max(1, log2(NUM_CH)), local
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_ch  in  CW  destination channel of sample
- in_data  in  DATA_W  sample value
- rd_start  in  1  one-cycle pulse: request a tap burst
- rd_ch  in  CW  channel to read
- rd_ntaps  in  AW+1  taps requested, 1..DEPTH
- busy  out  1  burst in progress
- out_valid  out  1  out_data holds a tap
- out_data  out  DATA_W  tap sample
- out_tap  out  AW  tap index, 0 = newest
- out_last  out  1  final tap of burst

## Operation
- Storage is a single NUM_CH*DEPTH word array addressed {ch, ptr}. It is inferred as simple dual-port RAM and is not reset.
- Per-channel state: wptr[ch] (AW bits), fill[ch] (AW+1 bits, saturates at DEPTH).
- Write on in_valid & in_ready: mem[ch][wptr] <= in_data, wptr <= wptr+1 mod DEPTH, fill <= min(fill+1, DEPTH).
- in_ready = !(busy & in_ch == active channel). Writes to other channels proceed during a burst.
- Burst FSM:
  - IDLE: rd_start & rd_ch < NUM_CH & rd_ntaps != 0 latches the channel, the tap count n = min(rd_ntaps, DEPTH), base = wptr[ch] and fill[ch], then moves to ISSUE. Other requests are ignored.
  - ISSUE: issues one RAM read per cycle, tap k at address base-1-k mod DEPTH, k = 0..n-1. After the last read it moves to DRAIN.
  - DRAIN: waits for the last read to return, then moves to IDLE.
- rd_start while busy is ignored; no queueing.
- Tap k with k >= latched fill: behaviour is set by the Configuration section.
- out_tap = k; out_last = (k == n-1) & out_valid. There is no output backpressure.

## Timing
- Reset values: in_ready=1, busy=0, out_valid=0, out_data=0, out_tap=0, out_last=0, all wptr=0, all fill=0, FSM=IDLE.
- A write at edge E is visible to a burst accepted at edge E+1 or later.
- Burst accepted at edge E0:
  - busy is high from E0+ until out_last is sampled.
  - Tap k is valid in the cycle after edge E0+2+k, so latency to first tap is 2 cycles.
  - Taps are contiguous: out_valid stays high for exactly n cycles.
- busy falls on the edge after out_last. rd_start in that same cycle (busy still high) is ignored. The next request is accepted on the following edge.
- Wrap-around: for base=0 and k=0, the tap address is DEPTH-1.
- Reset asserted mid-burst: outputs are forced to reset values asynchronously. Stored samples remain but fill=0, so subsequent taps follow the zero-pad rule.

## Configuration
- FIR_RING_ZEROPAD_EN defined: taps with k >= fill output out_data=0. This gives FIR start-up zero-padding; out_valid and out_tap are unchanged.
- FIR_RING_ZEROPAD_EN undefined: the raw RAM contents are output for all taps. The fill counters and their logic are removed.

## Test plan
- Write 1..5 to ch0, burst ntaps=3: out_data 5,4,3, out_tap 0,1,2, first valid 2 cycles after accept, out_last on tap 2.
- Write 70 samples (values 0..69) to ch1 with DEPTH=64, burst ntaps=64: out_data 69 down to 6, with correct address wrap.
- ZEROPAD_EN, after reset write 2 samples (A,B) to ch0, burst ntaps=4: B, A, 0, 0. Without the macro, the last two taps carry stale RAM contents.
- During a ch0 burst: in_ch=0 gives in_ready=0 and no write; in_ch=1 gives in_ready=1 and the write lands. The ch0 burst output is unchanged.
- rd_start with ntaps=0, rd_ch=NUM_CH, or while busy: no burst, busy stays at its current value. ntaps=DEPTH+1 yields DEPTH taps.
- Reset pulsed at tap 2 of an 8-tap burst: out_valid and busy drop immediately, wptr=0, fill=0, in_ready=1.
